// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode barrel shifter (SLL/SRL/SRA/ROL/ROR/pass) for the ALU execute path.
// One register stage per shift-amount bit: stage k shifts by 2^k when shamt[k] is set.
// The whole pipeline advances together under a single valid/ready stall signal.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH),
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OpSll = 3'd0;
  localparam logic [2:0] OpSrl = 3'd1;
  localparam logic [2:0] OpSra = 3'd2;
  localparam logic [2:0] OpRol = 3'd3;
  localparam logic [2:0] OpRor = 3'd4;

  // Stage registers
  logic [SHW-1:0]   v_q;
  logic [WIDTH-1:0] d_q   [SHW];
  logic [SHW-1:0]   c_q;
  logic [2:0]       op_q  [SHW];
  logic [SHW-1:0]   s_q   [SHW];
  logic [TAG_W-1:0] tag_q [SHW];

  // Next-state for every stage
  logic [SHW-1:0]   nxt_v;
  logic [WIDTH-1:0] nxt_d   [SHW];
  logic [SHW-1:0]   nxt_c;
  logic [2:0]       nxt_op  [SHW];
  logic [SHW-1:0]   nxt_s   [SHW];
  logic [TAG_W-1:0] nxt_tag [SHW];

  // Per-stage working values
  logic             cur_v;
  logic [WIDTH-1:0] cur_d;
  logic             cur_c;
  logic [2:0]       cur_op;
  logic [SHW-1:0]   cur_s;
  logic [SHW-1:0]   s_bits;
  logic [TAG_W-1:0] cur_tag;
  logic [SHW-1:0]   hi_idx;
  logic [SHW-1:0]   lo_idx;
  logic             do_sh;
  int unsigned      amt;

  logic advance;

  // Global stall: everything moves only when the output slot is free or being drained
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[SHW-1];
  assign out_data  = d_q[SHW-1];
  assign out_carry = c_q[SHW-1];
  assign out_tag   = tag_q[SHW-1];

  // Per-stage conditional shift by 2^k and carry update
  always_comb begin
    nxt_v   = '0;
    nxt_c   = '0;
    cur_v   = 1'b0;
    cur_d   = '0;
    cur_c   = 1'b0;
    cur_op  = '0;
    cur_s   = '0;
    s_bits  = '0;
    cur_tag = '0;
    hi_idx  = '0;
    lo_idx  = '0;
    do_sh   = 1'b0;
    amt     = 0;
    for (int k = 0; k < SHW; k++) begin
      nxt_d[k]   = '0;
      nxt_op[k]  = '0;
      nxt_s[k]   = '0;
      nxt_tag[k] = '0;
    end
    for (int k = 0; k < SHW; k++) begin
      if (k == 0) begin
        // Bubbles enter as all-zero so an empty slot never shows stale data
        cur_v   = in_valid;
        cur_d   = in_valid ? in_data : '0;
        cur_c   = 1'b0;
        cur_op  = in_valid ? in_op : '0;
        cur_s   = in_valid ? in_shamt : '0;
        cur_tag = in_valid ? in_tag : '0;
      end else begin
        cur_v   = v_q[k-1];
        cur_d   = d_q[k-1];
        cur_c   = c_q[k-1];
        cur_op  = op_q[k-1];
        cur_s   = s_q[k-1];
        cur_tag = tag_q[k-1];
      end
      amt    = 32'd1 << k;
      hi_idx = SHW'(WIDTH - amt);
      lo_idx = SHW'(amt - 1);
      s_bits = cur_s >> k;
      do_sh  = s_bits[0] && (cur_op <= OpRor);

      nxt_v[k]   = cur_v;
      nxt_op[k]  = cur_op;
      nxt_s[k]   = cur_s;
      nxt_tag[k] = cur_tag;
      nxt_d[k]   = cur_d;
      nxt_c[k]   = cur_c;
      if (do_sh) begin
        unique case (cur_op)
          OpSll: begin
            nxt_d[k] = cur_d << amt;
            nxt_c[k] = cur_d[hi_idx];
          end
          OpSrl: begin
            nxt_d[k] = cur_d >> amt;
            nxt_c[k] = cur_d[lo_idx];
          end
          // MSB is preserved by every arithmetic step, so it is still the original sign
          OpSra: begin
            nxt_d[k] = WIDTH'($signed(cur_d) >>> amt);
            nxt_c[k] = cur_d[lo_idx];
          end
          OpRol: begin
            nxt_d[k] = (cur_d << amt) | (cur_d >> (WIDTH - amt));
            nxt_c[k] = cur_d[hi_idx];
          end
          OpRor: begin
            nxt_d[k] = (cur_d >> amt) | (cur_d << (WIDTH - amt));
            nxt_c[k] = cur_d[lo_idx];
          end
          default: begin
            nxt_d[k] = cur_d;
            nxt_c[k] = cur_c;
          end
        endcase
      end
    end
  end

  // Stage registers: synchronous clear, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        d_q[k]   <= '0;
        op_q[k]  <= '0;
        s_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else if (advance) begin
      v_q <= nxt_v;
      c_q <= nxt_c;
      for (int k = 0; k < SHW; k++) begin
        d_q[k]   <= nxt_d[k];
        op_q[k]  <= nxt_op[k];
        s_q[k]   <= nxt_s[k];
        tag_q[k] <= nxt_tag[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter at WIDTH=32, TAG_W=5.
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;
  logic [4:0]  out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  pipelined_barrel_shifter #(
    .WIDTH(32),
    .TAG_W(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_carry(out_carry),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  // Issue one op into an idle pipeline and wait (bounded) for its result.
  // Called and returns at 1ns after a rising edge. lat = -1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s,
                        input logic [4:0] t, output logic [31:0] od, output logic oc,
                        output logic [4:0] ot, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_shamt  = s;
    in_tag    = t;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'h0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    od = out_data;
    oc = out_carry;
    ot = out_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
    n_cmp++; if (out_carry !== 1'b0) begin n_bad++; $display("FAIL reset out_carry: got %b want 0", out_carry); end
    n_cmp++; if (out_tag !== 5'h0) begin n_bad++; $display("FAIL reset out_tag: got %h want 0", out_tag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sll();
    logic [31:0] vd[3] = '{32'h8000_0001, 32'h0000_0003, 32'hFFFF_FFFF};
    logic [4:0]  vs[3] = '{5'd1, 5'd31, 5'd16};
    logic [4:0]  vt[3] = '{5'd3, 5'd7, 5'd9};
    logic [31:0] ed[3] = '{32'h0000_0002, 32'h8000_0000, 32'hFFFF_0000};
    logic        ec[3] = '{1'b1, 1'b1, 1'b1};
    logic [31:0] od;
    logic        oc;
    logic [4:0]  ot;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_op(3'd0, vd[i], vs[i], vt[i], od, oc, ot, lat);
      n_cmp++; if (od !== ed[i]) begin n_bad++; $display("FAIL sll[%0d] data: got %h want %h", i, od, ed[i]); end
      n_cmp++; if (oc !== ec[i]) begin n_bad++; $display("FAIL sll[%0d] carry: got %b want %b", i, oc, ec[i]); end
      n_cmp++; if (ot !== vt[i]) begin n_bad++; $display("FAIL sll[%0d] tag: got %h want %h", i, ot, vt[i]); end
      n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL sll[%0d] latency: got %0d want 5", i, lat); end
    end
  endtask

  task automatic test_shift_right();
    logic [2:0]  vo[5] = '{3'd2, 3'd1, 3'd1, 3'd2, 3'd1};
    logic [31:0] vd[5] = '{32'h8000_0010, 32'h8000_0010, 32'h0000_000F, 32'h8000_0000,
                           32'h8000_0000};
    logic [4:0]  vs[5] = '{5'd4, 5'd4, 5'd4, 5'd31, 5'd31};
    logic [31:0] ed[5] = '{32'hF800_0001, 32'h0800_0001, 32'h0000_0000, 32'hFFFF_FFFF,
                           32'h0000_0001};
    logic        ec[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] od;
    logic        oc;
    logic [4:0]  ot;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(vo[i], vd[i], vs[i], 5'(i + 10), od, oc, ot, lat);
      n_cmp++; if (od !== ed[i]) begin n_bad++; $display("FAIL sr[%0d] data: got %h want %h", i, od, ed[i]); end
      n_cmp++; if (oc !== ec[i]) begin n_bad++; $display("FAIL sr[%0d] carry: got %b want %b", i, oc, ec[i]); end
      n_cmp++; if (ot !== 5'(i + 10)) begin n_bad++; $display("FAIL sr[%0d] tag: got %h want %h", i, ot, 5'(i + 10)); end
      n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL sr[%0d] latency: got %0d want 5", i, lat); end
    end
  endtask

  task automatic test_rotate();
    logic [2:0]  vo[4] = '{3'd4, 3'd3, 3'd3, 3'd4};
    logic [31:0] vd[4] = '{32'h0000_0001, 32'h8000_0000, 32'h1234_5678, 32'h1234_5678};
    logic [4:0]  vs[4] = '{5'd1, 5'd31, 5'd4, 5'd8};
    logic [31:0] ed[4] = '{32'h8000_0000, 32'h4000_0000, 32'h2345_6781, 32'h7812_3456};
    logic        ec[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] od;
    logic        oc;
    logic [4:0]  ot;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(vo[i], vd[i], vs[i], 5'(i + 20), od, oc, ot, lat);
      n_cmp++; if (od !== ed[i]) begin n_bad++; $display("FAIL rot[%0d] data: got %h want %h", i, od, ed[i]); end
      n_cmp++; if (oc !== ec[i]) begin n_bad++; $display("FAIL rot[%0d] carry: got %b want %b", i, oc, ec[i]); end
      n_cmp++; if (ot !== 5'(i + 20)) begin n_bad++; $display("FAIL rot[%0d] tag: got %h want %h", i, ot, 5'(i + 20)); end
    end
  endtask

  task automatic test_zero_shift();
    logic [31:0] od;
    logic        oc;
    logic [4:0]  ot;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      run_op(3'(i), 32'hDEAD_BEEF, 5'd0, 5'(i), od, oc, ot, lat);
      n_cmp++; if (od !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL zero[op%0d] data: got %h want deadbeef", i, od); end
      n_cmp++; if (oc !== 1'b0) begin n_bad++; $display("FAIL zero[op%0d] carry: got %b want 0", i, oc); end
    end
    // Pass-through ignores a nonzero shift amount
    run_op(3'd6, 32'hDEAD_BEEF, 5'd7, 5'd1, od, oc, ot, lat);
    n_cmp++; if (od !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL pass data: got %h want deadbeef", od); end
    n_cmp++; if (oc !== 1'b0) begin n_bad++; $display("FAIL pass carry: got %b want 0", oc); end
  endtask

  task automatic test_back_to_back();
    // SLL of 0xFF by i for i = 0..7, tag i+1
    logic [31:0] exp_d[8] = '{32'h0000_00FF, 32'h0000_01FE, 32'h0000_03FC, 32'h0000_07F8,
                              32'h0000_0FF0, 32'h0000_1FE0, 32'h0000_3FC0, 32'h0000_7F80};
    int tx    = 0;
    int rx    = 0;
    int cyc   = 0;
    int extra = 0;
    while (rx < 8 && cyc < 60) begin
      cyc++;
      out_ready = !(cyc >= 6 && cyc <= 9);
      in_valid  = (tx < 8);
      in_op     = 3'd0;
      in_data   = 32'h0000_00FF;
      in_shamt  = 5'(tx);
      in_tag    = 5'(tx + 1);
      #1;
      if (cyc >= 6 && cyc <= 9) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b in_ready cyc %0d: got %b want 0", cyc, in_ready); end
      end
      if (out_valid === 1'b1) begin
        n_cmp++; if (out_data !== exp_d[rx]) begin n_bad++; $display("FAIL b2b data[%0d] cyc %0d: got %h want %h", rx, cyc, out_data, exp_d[rx]); end
        n_cmp++; if (out_tag !== 5'(rx + 1)) begin n_bad++; $display("FAIL b2b tag[%0d] cyc %0d: got %h want %h", rx, cyc, out_tag, 5'(rx + 1)); end
        n_cmp++; if (out_carry !== 1'b0) begin n_bad++; $display("FAIL b2b carry[%0d]: got %b want 0", rx, out_carry); end
        if (out_ready) rx++;
      end
      if (in_valid && in_ready) tx++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (rx != 8) begin n_bad++; $display("FAIL b2b results received: got %0d want 8", rx); end
    n_cmp++; if (tx != 8) begin n_bad++; $display("FAIL b2b ops accepted: got %0d want 8", tx); end
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) extra++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL b2b duplicate results: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] od;
    logic        oc;
    logic [4:0]  ot;
    int          lat;
    int          stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_data  = 32'(i + 1);
      in_shamt = 5'd0;
      in_tag   = 5'(i + 1);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid full before reset: got %b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rstmid out_data: got %h want 0", out_data); end
    n_cmp++; if (out_tag !== 5'h0) begin n_bad++; $display("FAIL rstmid out_tag: got %h want 0", out_tag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b0) stale++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL rstmid stale results: got %0d want 0", stale); end
    // Pipeline still usable after the flush
    run_op(3'd1, 32'hF000_0000, 5'd28, 5'd17, od, oc, ot, lat);
    n_cmp++; if (od !== 32'h0000_000F) begin n_bad++; $display("FAIL rstmid post data: got %h want 0000000f", od); end
    n_cmp++; if (ot !== 5'd17) begin n_bad++; $display("FAIL rstmid post tag: got %h want 11", ot); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_shamt  = 5'd0;
    in_op     = 3'd0;
    in_tag    = 5'd0;
    out_ready = 1'b1;
    test_reset();
    test_sll();
    test_shift_right();
    test_rotate();
    test_zero_shift();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
